// File: rtl/branch_issue_arbiter.sv
// Branch issue arbiter: round-robin selection of one branch RS request per
// cycle into a single issue register feeding the branch functional unit.
// Mispredict squashes kill matching requests and the held packet; resolves
// clear branch-mask bits of surviving packets.
module branch_issue_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 128,
  parameter int BMASK_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BMASK_W-1:0]     req_bmask,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  output logic [NUM_REQ-1:0]             req_grant,
  input  logic                           fu_ready,
  output logic                           issue_valid,
  output logic [BMASK_W-1:0]             issue_bmask,
  output logic [PAYLOAD_W-1:0]           issue_payload,
  input  logic                           squash_valid,
  input  logic [BMASK_W-1:0]             squash_mask,
  input  logic                           resolve_valid,
  input  logic [BMASK_W-1:0]             resolve_mask,
  output logic [CNT_W-1:0]               stall_cycles
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Control state: round-robin pointer, issue-register valid, stall counter.
  logic [IDX_W-1:0]     rr_ptr_p0;
  logic                 vld_p1;
  logic [CNT_W-1:0]     stall_p1;

  // Data state: the held branch packet.
  logic [BMASK_W-1:0]   bmask_p1;
  logic [PAYLOAD_W-1:0] payload_p1;

  // Per-cycle decode.
  logic [BMASK_W-1:0]   clr;
  logic                 held_hit;
  logic                 can_load;
  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     scan_idx;
  logic                 grant_any;
  logic [BMASK_W-1:0]   win_bmask;
  logic [PAYLOAD_W-1:0] win_payload;

  // A mask is killed when any of its checkpoints is being squashed.
  function automatic logic sq_hit(input logic               sv,
                                  input logic [BMASK_W-1:0] sm,
                                  input logic [BMASK_W-1:0] m);
    return sv && (|(m & sm));
  endfunction

  // Saturating increment: the counter sticks at its all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Squash/resolve decode and per-requester eligibility.
  always_comb begin
    clr      = resolve_valid ? resolve_mask : '0;
    held_hit = sq_hit(squash_valid, squash_mask, bmask_p1);
    can_load = !vld_p1 || fu_ready || held_hit;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    !sq_hit(squash_valid, squash_mask, req_bmask[i*BMASK_W +: BMASK_W]);
    end
  end

  // Round-robin scan starting at rr_ptr; index arithmetic wraps since NUM_REQ is a power of 2.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr_p0 + IDX_W'(k);
      if (!found && eligible[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Grant is combinational and suppressed entirely while reset is asserted.
  always_comb begin
    grant_any   = can_load && found && !reset;
    req_grant   = grant_any ? (NUM_REQ'(1) << winner) : '0;
    win_bmask   = req_bmask[int'(winner)*BMASK_W +: BMASK_W];
    win_payload = req_payload[int'(winner)*PAYLOAD_W +: PAYLOAD_W];
  end

  // Round-robin pointer advances past the winner on every grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_p0 <= '0;
    end else if (grant_any) begin
      rr_ptr_p0 <= winner + IDX_W'(1);
    end
  end

  // --- stage p1: issue register (load winner, drain, or hold with resolve clear) ---
  // Squash is folded into can_load first, so resolve only ever touches survivors.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      bmask_p1   <= '0;
      payload_p1 <= '0;
    end else if (can_load) begin
      vld_p1 <= found;
      if (found) begin
        bmask_p1   <= win_bmask & ~clr;
        payload_p1 <= win_payload;
      end
    end else begin
      bmask_p1 <= bmask_p1 & ~clr;
    end
  end

  // Stall counter: live, unsquashed packet that the FU is not taking.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_p1 <= '0;
    end else if (vld_p1 && !fu_ready && !held_hit) begin
      stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign issue_valid   = vld_p1;
  assign issue_bmask   = bmask_p1;
  assign issue_payload = payload_p1;
  assign stall_cycles  = stall_p1;

endmodule

// File: tb/tb_branch_issue_arbiter.sv
// Directed bench for branch_issue_arbiter: a per-cycle vector table plus a
// few hand-written multi-cycle sequences (stall saturation, drain, squash).
module tb_branch_issue_arbiter;

  localparam int NR = 4;
  localparam int PW = 128;
  localparam int BW = 4;
  localparam int CW = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR*BW-1:0]     req_bmask;
  logic [NR*PW-1:0]     req_payload;
  logic [NR-1:0]        req_grant;
  logic                 fu_ready;
  logic                 issue_valid;
  logic [BW-1:0]        issue_bmask;
  logic [PW-1:0]        issue_payload;
  logic                 squash_valid;
  logic [BW-1:0]        squash_mask;
  logic                 resolve_valid;
  logic [BW-1:0]        resolve_mask;
  logic [CW-1:0]        stall_cycles;

  // Narrow-counter instance sharing all inputs, used for the saturation check.
  logic [NR-1:0]        s_grant;
  logic                 s_valid;
  logic [BW-1:0]        s_bmask;
  logic [PW-1:0]        s_payload;
  logic [2:0]           s_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  branch_issue_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .BMASK_W(BW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_bmask(req_bmask),
    .req_payload(req_payload), .req_grant(req_grant), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_bmask(issue_bmask), .issue_payload(issue_payload),
    .squash_valid(squash_valid), .squash_mask(squash_mask), .resolve_valid(resolve_valid),
    .resolve_mask(resolve_mask), .stall_cycles(stall_cycles));

  branch_issue_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .BMASK_W(BW), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_bmask(req_bmask),
    .req_payload(req_payload), .req_grant(s_grant), .fu_ready(fu_ready),
    .issue_valid(s_valid), .issue_bmask(s_bmask), .issue_payload(s_payload),
    .squash_valid(squash_valid), .squash_mask(squash_mask), .resolve_valid(resolve_valid),
    .resolve_mask(resolve_mask), .stall_cycles(s_stall));

  typedef struct {
    logic           rst;
    logic [NR-1:0]  rv;
    logic [NR*BW-1:0] bm;
    logic           fr;
    logic           sqv;
    logic [BW-1:0]  sqm;
    logic           rsv;
    logic [BW-1:0]  rsm;
    logic [NR-1:0]  exp_grant;
    logic           exp_vld;
    logic           chk_data;
    logic [BW-1:0]  exp_bmask;
    logic [7:0]     exp_tag;
    logic [CW-1:0]  exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [PW-1:0] pl(input logic [7:0] tag);
    return {(PW/8){tag}};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] rv, input logic [15:0] bm,
                     input logic fr, input logic sqv, input logic [3:0] sqm,
                     input logic rsv, input logic [3:0] rsm, input logic [3:0] eg,
                     input logic ev, input logic cd, input logic [3:0] ebm,
                     input logic [7:0] etag, input logic [15:0] est);
    vec_t v;
    v.rst = rst; v.rv = rv; v.bm = bm; v.fr = fr; v.sqv = sqv; v.sqm = sqm;
    v.rsv = rsv; v.rsm = rsm; v.exp_grant = eg; v.exp_vld = ev; v.chk_data = cd;
    v.exp_bmask = ebm; v.exp_tag = etag; v.exp_stall = est;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [3:0] rv, input logic [15:0] bm,
                       input logic fr, input logic sqv, input logic [3:0] sqm,
                       input logic rsv, input logic [3:0] rsm);
    reset = rst; req_valid = rv; req_bmask = bm; fu_ready = fr;
    squash_valid = sqv; squash_mask = sqm; resolve_valid = rsv; resolve_mask = rsm;
  endtask

  initial begin
    drive(1'b1, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < NR; i++) begin
      logic [7:0] t;
      t = 8'hA0 + 8'(i);
      req_payload[i*PW +: PW] = pl(t);
    end

    //   rst rv    bm        fr sqv sqm  rsv rsm  grant vld cd bmask tag    stall
    add(1, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 4'h0, 8'h00, 0);
    add(1, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 4'h0, 8'h00, 0);
    // round robin, back-to-back issue
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h1, 1, 1, 4'h0, 8'hA0, 0);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h2, 1, 1, 4'h0, 8'hA1, 0);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h4, 1, 1, 4'h0, 8'hA2, 0);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h8, 1, 1, 4'h0, 8'hA3, 0);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h1, 1, 1, 4'h0, 8'hA0, 0);
    // backpressure
    add(0, 4'h2, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA0, 1);
    add(0, 4'h2, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA0, 2);
    add(0, 4'h2, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA0, 3);
    add(0, 4'h2, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h2, 1, 1, 4'h0, 8'hA1, 3);
    add(0, 4'h4, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h4, 1, 1, 4'h0, 8'hA2, 3);
    add(0, 4'h8, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h8, 1, 1, 4'h0, 8'hA3, 3);
    // squash requester 0 with rr_ptr=0: grant 1, pointer moves to 2
    add(0, 4'h3, 16'h0001, 1, 1, 4'h1, 0, 4'h0, 4'h2, 1, 1, 4'h0, 8'hA1, 3);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h4, 1, 1, 4'h0, 8'hA2, 3);
    // squash held packet frees the register the same cycle
    add(0, 4'h8, 16'h4000, 1, 0, 4'h0, 0, 4'h0, 4'h8, 1, 1, 4'h4, 8'hA3, 3);
    add(0, 4'h4, 16'h0000, 0, 1, 4'h4, 0, 4'h0, 4'h4, 1, 1, 4'h0, 8'hA2, 3);
    // resolve vs squash on a held packet
    add(0, 4'h8, 16'hA000, 1, 0, 4'h0, 0, 4'h0, 4'h8, 1, 1, 4'hA, 8'hA3, 3);
    add(0, 4'h0, 16'h0000, 0, 1, 4'h1, 1, 4'h8, 4'h0, 1, 1, 4'h2, 8'hA3, 4);
    // resolve applied to a packet as it loads
    add(0, 4'h1, 16'h0003, 1, 0, 4'h0, 1, 4'h1, 4'h1, 1, 1, 4'h2, 8'hA0, 4);
    // squash hits every requester: no grant, register drains
    add(0, 4'hF, 16'h1111, 1, 1, 4'h1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 8'h00, 4);
    // build up stall to 7, then reset mid-stall
    add(0, 4'h2, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h2, 1, 1, 4'h0, 8'hA1, 4);
    add(0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA1, 5);
    add(0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA1, 6);
    add(0, 4'h0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 8'hA1, 7);
    add(1, 4'hF, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 4'h0, 8'h00, 0);
    add(0, 4'hF, 16'h0000, 1, 0, 4'h0, 0, 4'h0, 4'h1, 1, 1, 4'h0, 8'hA0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].rv, vecs[i].bm, vecs[i].fr, vecs[i].sqv,
            vecs[i].sqm, vecs[i].rsv, vecs[i].rsm);
      #1;
      chk($sformatf("v%0d grant", i), PW'(req_grant), PW'(vecs[i].exp_grant));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d issue_valid", i), PW'(issue_valid), PW'(vecs[i].exp_vld));
      chk($sformatf("v%0d stall_cycles", i), PW'(stall_cycles), PW'(vecs[i].exp_stall));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d issue_bmask", i), PW'(issue_bmask), PW'(vecs[i].exp_bmask));
        chk($sformatf("v%0d issue_payload", i), issue_payload, pl(vecs[i].exp_tag));
      end
    end

    // Long stall: 16-bit counter reaches 10, 3-bit counter saturates at 7.
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    end
    @(posedge clock); #1;
    chk("long stall count", PW'(stall_cycles), PW'(16'd10));
    chk("saturated count", PW'(s_stall), PW'(3'd7));
    chk("long stall payload held", issue_payload, pl(8'hA0));

    // FU consumes with nothing requesting: packet leaves exactly once.
    @(negedge clock);
    drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    @(posedge clock); #1;
    chk("drain valid", PW'(issue_valid), PW'(1'b0));
    chk("drain stall unchanged", PW'(stall_cycles), PW'(16'd10));

    // Load req 0 with bmask 0001 (rr_ptr=1 wraps around to 0).
    @(negedge clock);
    drive(1'b0, 4'h1, 16'h0001, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    #1;
    chk("wrap grant", PW'(req_grant), PW'(4'h1));
    @(posedge clock); #1;
    chk("wrap bmask", PW'(issue_bmask), PW'(4'h1));

    // Squash the held packet while stalled with no requesters: register empties, no stall count.
    @(negedge clock);
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0);
    #1;
    chk("squash-held grant", PW'(req_grant), PW'(4'h0));
    @(posedge clock); #1;
    chk("squash-held valid", PW'(issue_valid), PW'(1'b0));
    chk("squash-held stall", PW'(stall_cycles), PW'(16'd10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
